l2_arbiter_rr: RTL and testbench
================================

# l2_arbiter_rr

Parametrised arbiter multiplexing NUM_CLIENTS L1-side requesters (I-cache, D-cache, prefetcher, DMA, ...) onto the single-ported L2 line interface. It generalises the two-cache I/D arbiter: N clients, configurable address/line width, and a selectable round-robin or fixed-priority policy. It holds a grant for one full L2 transaction. Sits between the L1 caches and L2 in the lc3b memory hierarchy.

## Interface
- NUM_CLIENTS, 2: number of requesters, legal 2..8; client 0 is highest fixed priority.
- ADDR_WIDTH, 16: address width (lc3b_word).
- LINE_WIDTH, 128: line width (lc3b_line).
- RR_MODE, 1: 1 = round-robin, 0 = fixed priority (lowest index wins).
- GW (localparam): max(1, $clog2(NUM_CLIENTS)).

- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- l1_addr  in  NUM_CLIENTS*ADDR_WIDTH  client i address at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- l1_wdata  in  NUM_CLIENTS*LINE_WIDTH  client i write line, same packing.
- l1_read  in  NUM_CLIENTS  per-client read request.
- l1_write  in  NUM_CLIENTS  per-client write request.
- l1_rdata  out  LINE_WIDTH  shared read data, equal to l2_rdata at all times.
- l1_resp  out  NUM_CLIENTS  per-client completion, one-hot or zero.
- l2_rdata  in  LINE_WIDTH  L2 read line.
- l2_resp  in  1  L2 completion.
- l2_addr  out  ADDR_WIDTH  address of granted client.
- l2_wdata  out  LINE_WIDTH  write line of granted client.
- l2_read  out  1  read strobe to L2.
- l2_write  out  1  write strobe to L2.
- grant_id  out  GW  index of current/last granted client.
- busy  out  1  high while a transaction is outstanding.

## Operation
- Client i requests when l1_read[i] | l1_write[i]; clients hold addr/wdata/strobes stable until their l1_resp pulse, then drop for at least one cycle.
- Read and write both high on one client: write wins, read ignored for that transaction.
- FSM states IDLE, BUSY.
  - IDLE: l2_read = l2_write = 0, l2_addr = 0, l2_wdata = 0, l1_resp = 0. If any request: select winner, register grant_id, go BUSY. No request: stay.
  - BUSY: l2_addr, l2_wdata, l2_read, l2_write combinationally mirror granted client's live inputs (write-over-read applied). On l2_resp: l1_resp[grant_id] = 1 same cycle, go IDLE, update round-robin pointer.
- Selection: RR_MODE=1 — first requester scanning ptr, ptr+1, ... wrapping mod NUM_CLIENTS; after completion ptr = (grant_id+1) mod NUM_CLIENTS. RR_MODE=0 — lowest-index requester; ptr unused and held at 0.
- l2_resp in IDLE: ignored, no l1_resp.
- Granted client dropping its request mid-BUSY: protocol violation; grant held until l2_resp, l2 strobes follow inputs (may go low).
- Reset (asynchronous, any state): state IDLE, grant_id 0, ptr 0, busy 0, all l2 strobes and l1_resp 0 immediately; outstanding transaction abandoned.

## Timing
- Reset values: l2_read 0, l2_write 0, l2_addr 0, l2_wdata 0, l1_resp 0, grant_id 0, busy 0; l1_rdata follows l2_rdata.
- Request first visible in cycle 0 (IDLE) -> grant registered at end of cycle 0 -> l2 strobe high from cycle 1; busy high from cycle 1.
- l2_resp in cycle k -> l1_resp pulse in cycle k (combinational), IDLE in k+1, next grant registered end of k+1, next l2 strobe in k+2.
- l1_resp is exactly one cycle per l2_resp; never to a non-granted client.
- Mandatory one IDLE cycle between transactions; no back-to-back grant.
- Simultaneous new request and l2_resp: new request only considered in the following IDLE cycle, using the updated ptr.

## Test plan
- Reset: rst_n low mid-BUSY with l2_read=1 -> l2_read drops to 0 without a clock edge; after release grant_id=0, busy=0.
- Single read, N=2: client 1 read addr 0x1230 in cycle 0 -> l2_read=1, l2_addr=0x1230 in cycle 1; l2_resp in cycle 4 with rdata 0xDEAD... -> l1_resp=2'b10 in cycle 4, l1_rdata matches, busy=0 cycle 5.
- Round-robin fairness, N=4, RR_MODE=1: all four request continuously, 1-cycle L2 -> grant order 0,1,2,3,0,...; each transaction 3 cycles.
- Fixed priority, N=4, RR_MODE=0: clients 0 and 2 request continuously -> client 0 granted every transaction, client 2 never.
- Write precedence: client 0 asserts read and write, wdata 0xA5..A5, addr 0x0040 -> l2_write=1, l2_read=0, l2_wdata=0xA5..A5.
- Stray response: l2_resp pulsed while IDLE -> l1_resp stays 0, state unchanged, ptr unchanged.

Source files
------------

// File: rtl/l2_arbiter_rr.sv
// N-client arbiter onto the single-ported L2 line interface.
// Holds one grant per L2 transaction; round-robin or fixed-priority selection.
module l2_arbiter_rr #(
   parameter int NUM_CLIENTS = 2,
   parameter int ADDR_WIDTH  = 16,
   parameter int LINE_WIDTH  = 128,
   parameter bit RR_MODE     = 1'b1,
   localparam int GW         = (NUM_CLIENTS <= 2) ? 1 : $clog2(NUM_CLIENTS)
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] l1_addr,
   input  logic [NUM_CLIENTS*LINE_WIDTH-1:0] l1_wdata,
   input  logic [NUM_CLIENTS-1:0]            l1_read,
   input  logic [NUM_CLIENTS-1:0]            l1_write,
   output logic [LINE_WIDTH-1:0]             l1_rdata,
   output logic [NUM_CLIENTS-1:0]            l1_resp,
   input  logic [LINE_WIDTH-1:0]             l2_rdata,
   input  logic                              l2_resp,
   output logic [ADDR_WIDTH-1:0]             l2_addr,
   output logic [LINE_WIDTH-1:0]             l2_wdata,
   output logic                              l2_read,
   output logic                              l2_write,
   output logic [GW-1:0]                     grant_id,
   output logic                              busy
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                state_q, state_d;
   logic [GW-1:0]         grant_q, grant_d;
   logic [GW-1:0]         ptr_q, ptr_d;
   logic [GW-1:0]         base_ptr;
   logic [GW-1:0]         winner;
   logic                  found;
   logic [GW:0]           scan_idx;
   logic [NUM_CLIENTS-1:0] req;

   logic [ADDR_WIDTH-1:0] addr_arr  [NUM_CLIENTS];
   logic [LINE_WIDTH-1:0] wdata_arr [NUM_CLIENTS];

   for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_unpack
      assign addr_arr[g]  = l1_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[g] = l1_wdata[g*LINE_WIDTH +: LINE_WIDTH];
   end

   assign req      = l1_read | l1_write;
   assign base_ptr = RR_MODE ? ptr_q : '0;
   assign l1_rdata = l2_rdata;
   assign grant_id = grant_q;
   assign busy     = (state_q == BUSY);

   // Scan clients starting at the base pointer, wrapping; first requester wins.
   always_comb begin
      found    = 1'b0;
      winner   = '0;
      scan_idx = '0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         scan_idx = {1'b0, base_ptr} + (GW+1)'(i);
         if (scan_idx >= (GW+1)'(NUM_CLIENTS))
            scan_idx = scan_idx - (GW+1)'(NUM_CLIENTS);
         if (!found && req[scan_idx[GW-1:0]]) begin
            found  = 1'b1;
            winner = scan_idx[GW-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      ptr_d    = ptr_q;
      l2_addr  = '0;
      l2_wdata = '0;
      l2_read  = 1'b0;
      l2_write = 1'b0;
      l1_resp  = '0;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               grant_d = winner;
               state_d = BUSY;
            end
         end
         BUSY: begin
            // Granted client's live inputs pass straight through; write beats read.
            l2_addr  = addr_arr[grant_q];
            l2_wdata = wdata_arr[grant_q];
            l2_write = l1_write[grant_q];
            l2_read  = l1_read[grant_q] & ~l1_write[grant_q];
            if (l2_resp) begin
               l1_resp[grant_q] = 1'b1;
               state_d          = IDLE;
               if (RR_MODE)
                  ptr_d = (grant_q == GW'(NUM_CLIENTS - 1)) ? '0 : grant_q + GW'(1);
               else
                  ptr_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_l2_arbiter_rr.sv
// Directed bench for l2_arbiter_rr: a 2-client round-robin instance plus
// 4-client round-robin and fixed-priority instances sharing clock and reset.
module tb_l2_arbiter_rr;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   // 2-client round-robin instance
   logic [31:0]  a_addr;
   logic [255:0] a_wdata;
   logic [1:0]   a_read, a_write, a_l1_resp;
   logic [127:0] a_l1_rdata, a_l2_rdata, a_l2_wdata;
   logic         a_l2_resp, a_l2_read, a_l2_write, a_busy;
   logic [15:0]  a_l2_addr;
   logic [0:0]   a_grant;

   // 4-client round-robin instance
   logic [63:0]  b_addr;
   logic [511:0] b_wdata;
   logic [3:0]   b_read, b_write, b_l1_resp;
   logic [127:0] b_l1_rdata, b_l2_rdata, b_l2_wdata;
   logic         b_l2_resp, b_l2_read, b_l2_write, b_busy;
   logic [15:0]  b_l2_addr;
   logic [1:0]   b_grant;

   // 4-client fixed-priority instance
   logic [63:0]  c_addr;
   logic [511:0] c_wdata;
   logic [3:0]   c_read, c_write, c_l1_resp;
   logic [127:0] c_l1_rdata, c_l2_rdata, c_l2_wdata;
   logic         c_l2_resp, c_l2_read, c_l2_write, c_busy;
   logic [15:0]  c_l2_addr;
   logic [1:0]   c_grant;

   l2_arbiter_rr #(.NUM_CLIENTS(2), .ADDR_WIDTH(16), .LINE_WIDTH(128), .RR_MODE(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .l1_addr(a_addr), .l1_wdata(a_wdata),
      .l1_read(a_read), .l1_write(a_write), .l1_rdata(a_l1_rdata), .l1_resp(a_l1_resp),
      .l2_rdata(a_l2_rdata), .l2_resp(a_l2_resp), .l2_addr(a_l2_addr), .l2_wdata(a_l2_wdata),
      .l2_read(a_l2_read), .l2_write(a_l2_write), .grant_id(a_grant), .busy(a_busy));

   l2_arbiter_rr #(.NUM_CLIENTS(4), .ADDR_WIDTH(16), .LINE_WIDTH(128), .RR_MODE(1'b1)) dut_b (
      .clk(clk), .rst_n(rst_n), .l1_addr(b_addr), .l1_wdata(b_wdata),
      .l1_read(b_read), .l1_write(b_write), .l1_rdata(b_l1_rdata), .l1_resp(b_l1_resp),
      .l2_rdata(b_l2_rdata), .l2_resp(b_l2_resp), .l2_addr(b_l2_addr), .l2_wdata(b_l2_wdata),
      .l2_read(b_l2_read), .l2_write(b_l2_write), .grant_id(b_grant), .busy(b_busy));

   l2_arbiter_rr #(.NUM_CLIENTS(4), .ADDR_WIDTH(16), .LINE_WIDTH(128), .RR_MODE(1'b0)) dut_c (
      .clk(clk), .rst_n(rst_n), .l1_addr(c_addr), .l1_wdata(c_wdata),
      .l1_read(c_read), .l1_write(c_write), .l1_rdata(c_l1_rdata), .l1_resp(c_l1_resp),
      .l2_rdata(c_l2_rdata), .l2_resp(c_l2_resp), .l2_addr(c_l2_addr), .l2_wdata(c_l2_wdata),
      .l2_read(c_l2_read), .l2_write(c_l2_write), .grant_id(c_grant), .busy(c_busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change just after a rising edge; outputs are checked on the falling edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      total++;
      if (a_busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy got=%b want=0", a_busy); end
      total++;
      if (a_grant !== 1'b0) begin bad++; $display("[TB] FAIL rst_grant got=%0d want=0", a_grant); end
      total++;
      if ({a_l2_read, a_l2_write} !== 2'b00) begin bad++; $display("[TB] FAIL rst_strobes got=%b want=00", {a_l2_read, a_l2_write}); end
      total++;
      if (a_l2_addr !== 16'h0 || a_l2_wdata !== 128'h0) begin bad++; $display("[TB] FAIL rst_addr_wdata got=%h/%h want=0/0", a_l2_addr, a_l2_wdata); end
      total++;
      if (a_l1_resp !== 2'b00 || b_l1_resp !== 4'h0 || c_l1_resp !== 4'h0) begin bad++; $display("[TB] FAIL rst_l1_resp got=%b/%b/%b want=0", a_l1_resp, b_l1_resp, c_l1_resp); end
      total++;
      if (a_l1_rdata !== 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210) begin bad++; $display("[TB] FAIL rst_rdata_follow got=%h", a_l1_rdata); end
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Reach BUSY, then pull reset between edges
      next_cycle();
      a_read         = 2'b01;
      a_addr[15:0]   = 16'h0BEE;
      @(negedge clk);
      next_cycle();
      @(negedge clk);
      total++;
      if (a_l2_read !== 1'b1 || a_busy !== 1'b1) begin bad++; $display("[TB] FAIL pre_rst_busy got=%b%b want=11", a_l2_read, a_busy); end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (a_l2_read !== 1'b0) begin bad++; $display("[TB] FAIL async_rst_read got=%b want=0", a_l2_read); end
      total++;
      if (a_busy !== 1'b0 || a_l2_addr !== 16'h0) begin bad++; $display("[TB] FAIL async_rst_busy got=%b/%h want=0/0", a_busy, a_l2_addr); end
      a_read = 2'b00;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (a_grant !== 1'b0 || a_busy !== 1'b0) begin bad++; $display("[TB] FAIL post_rst got=%0d/%b want=0/0", a_grant, a_busy); end
   endtask

   task automatic test_single_read();
      next_cycle();
      a_read        = 2'b10;
      a_addr[31:16] = 16'h1230;
      @(negedge clk);
      total++;
      if (a_busy !== 1'b0 || a_l2_read !== 1'b0) begin bad++; $display("[TB] FAIL rd_cycle0 got=%b/%b want=0/0", a_busy, a_l2_read); end
      next_cycle();
      @(negedge clk);
      total++;
      if (a_l2_read !== 1'b1 || a_l2_addr !== 16'h1230) begin bad++; $display("[TB] FAIL rd_cycle1 got=%b/%h want=1/1230", a_l2_read, a_l2_addr); end
      total++;
      if (a_grant !== 1'b1 || a_busy !== 1'b1) begin bad++; $display("[TB] FAIL rd_grant got=%0d/%b want=1/1", a_grant, a_busy); end
      next_cycle();
      next_cycle();
      @(negedge clk);
      total++;
      if (a_l1_resp !== 2'b00 || a_busy !== 1'b1) begin bad++; $display("[TB] FAIL rd_wait got=%b/%b want=00/1", a_l1_resp, a_busy); end
      next_cycle();
      a_l2_resp  = 1'b1;
      a_l2_rdata = {8{16'hDEAD}};
      @(negedge clk);
      total++;
      if (a_l1_resp !== 2'b10) begin bad++; $display("[TB] FAIL rd_resp got=%b want=10", a_l1_resp); end
      total++;
      if (a_l1_rdata !== {8{16'hDEAD}}) begin bad++; $display("[TB] FAIL rd_rdata got=%h want=%h", a_l1_rdata, {8{16'hDEAD}}); end
      next_cycle();
      a_l2_resp = 1'b0;
      a_read    = 2'b00;
      @(negedge clk);
      total++;
      if (a_busy !== 1'b0 || a_l1_resp !== 2'b00) begin bad++; $display("[TB] FAIL rd_done got=%b/%b want=0/00", a_busy, a_l1_resp); end
   endtask

   task automatic test_write_precedence();
      next_cycle();
      a_read         = 2'b01;
      a_write        = 2'b01;
      a_addr[15:0]   = 16'h0040;
      a_wdata[127:0] = {16{8'hA5}};
      @(negedge clk);
      next_cycle();
      @(negedge clk);
      total++;
      if (a_l2_write !== 1'b1 || a_l2_read !== 1'b0) begin bad++; $display("[TB] FAIL wr_strobes got=w%b r%b want=w1 r0", a_l2_write, a_l2_read); end
      total++;
      if (a_l2_wdata !== {16{8'hA5}} || a_l2_addr !== 16'h0040) begin bad++; $display("[TB] FAIL wr_data got=%h/%h want=A5../0040", a_l2_wdata, a_l2_addr); end
      next_cycle();
      a_l2_resp = 1'b1;
      @(negedge clk);
      total++;
      if (a_l1_resp !== 2'b01) begin bad++; $display("[TB] FAIL wr_resp got=%b want=01", a_l1_resp); end
      next_cycle();
      a_l2_resp = 1'b0;
      a_read    = 2'b00;
      a_write   = 2'b00;
      @(negedge clk);
      total++;
      if (a_busy !== 1'b0) begin bad++; $display("[TB] FAIL wr_done got=%b want=0", a_busy); end
   endtask

   // Pointer is 1 after client 0 completed, so a stray response must leave it there.
   task automatic test_stray_resp();
      next_cycle();
      a_l2_resp = 1'b1;
      @(negedge clk);
      total++;
      if (a_l1_resp !== 2'b00 || a_busy !== 1'b0) begin bad++; $display("[TB] FAIL stray_resp got=%b/%b want=00/0", a_l1_resp, a_busy); end
      next_cycle();
      a_l2_resp = 1'b0;
      @(negedge clk);
      total++;
      if (a_busy !== 1'b0 || a_grant !== 1'b0) begin bad++; $display("[TB] FAIL stray_state got=%b/%0d want=0/0", a_busy, a_grant); end
      next_cycle();
      a_read = 2'b11;
      @(negedge clk);
      next_cycle();
      @(negedge clk);
      total++;
      if (a_grant !== 1'b1 || a_l2_addr !== 16'h1230) begin bad++; $display("[TB] FAIL stray_ptr got=%0d/%h want=1/1230", a_grant, a_l2_addr); end
      next_cycle();
      a_l2_resp = 1'b1;
      a_read    = 2'b00;
      next_cycle();
      a_l2_resp = 1'b0;
   endtask

   task automatic test_round_robin();
      logic [1:0]  exp_g;
      logic [15:0] exp_a;
      for (int i = 0; i < 4; i++) b_addr[i*16 +: 16] = 16'h1000 + 16'(i) * 16'h0111;
      next_cycle();
      b_read = 4'hF;
      @(negedge clk);
      for (int t = 0; t < 6; t++) begin
         exp_g = 2'(t % 4);
         exp_a = 16'h1000 + 16'(t % 4) * 16'h0111;
         next_cycle();
         b_l2_resp = 1'b1;
         @(negedge clk);
         total++;
         if (b_busy !== 1'b1 || b_grant !== exp_g) begin bad++; $display("[TB] FAIL rr_grant t=%0d got=%0d busy=%b want=%0d", t, b_grant, b_busy, exp_g); end
         total++;
         if (b_l1_resp !== (4'b0001 << exp_g) || b_l2_addr !== exp_a || b_l2_read !== 1'b1) begin bad++; $display("[TB] FAIL rr_resp t=%0d got=%b/%h want=%b/%h", t, b_l1_resp, b_l2_addr, 4'b0001 << exp_g, exp_a); end
         next_cycle();
         b_l2_resp = 1'b0;
         if (t == 5) b_read = 4'h0;
         @(negedge clk);
         total++;
         if (b_busy !== 1'b0 || b_l1_resp !== 4'h0) begin bad++; $display("[TB] FAIL rr_idle t=%0d got=%b/%b want=0/0000", t, b_busy, b_l1_resp); end
      end
   endtask

   task automatic test_fixed_priority();
      for (int i = 0; i < 4; i++) c_addr[i*16 +: 16] = 16'h2000 + 16'(i);
      next_cycle();
      c_read = 4'b0101;
      @(negedge clk);
      for (int t = 0; t < 4; t++) begin
         next_cycle();
         c_l2_resp = 1'b1;
         @(negedge clk);
         total++;
         if (c_grant !== 2'd0 || c_l1_resp !== 4'b0001 || c_l2_addr !== 16'h2000) begin bad++; $display("[TB] FAIL fp_grant t=%0d got=%0d/%b/%h want=0/0001/2000", t, c_grant, c_l1_resp, c_l2_addr); end
         next_cycle();
         c_l2_resp = 1'b0;
         if (t == 3) c_read = 4'h0;
         @(negedge clk);
         total++;
         if (c_busy !== 1'b0) begin bad++; $display("[TB] FAIL fp_idle t=%0d got=%b want=0", t, c_busy); end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      a_addr = '0; a_wdata = '0; a_read = '0; a_write = '0; a_l2_resp = 1'b0;
      a_l2_rdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      b_addr = '0; b_wdata = '0; b_read = '0; b_write = '0; b_l2_resp = 1'b0; b_l2_rdata = '0;
      c_addr = '0; c_wdata = '0; c_read = '0; c_write = '0; c_l2_resp = 1'b0; c_l2_rdata = '0;
      #2;
      test_reset();
      test_single_read();
      test_write_precedence();
      test_stray_resp();
      test_round_robin();
      test_fixed_priority();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
